// File: rtl/counter_m_monitor_if.sv
// Bundle of the signals between an observed mod-M counter and its monitor.
// The master drives the sampled counter and the clear; the monitor (slave) reports lock and error status.
// The interface itself has no storage and no flow control.
interface counter_m_monitor_if #(
  parameter int ERRW = 8
);
  logic            enable;
  logic [3:0]      count_M;
  logic            carry_out_M;
  logic            clear;
  logic            locked;
  logic            err_pulse;
  logic            err_sticky;
  logic [ERRW-1:0] err_count;
  logic [ERRW-1:0] wrap_count;

  modport master (
    output enable, count_M, carry_out_M, clear,
    input  locked, err_pulse, err_sticky, err_count, wrap_count
  );

  modport slave (
    input  enable, count_M, carry_out_M, clear,
    output locked, err_pulse, err_sticky, err_count, wrap_count
  );
endinterface

// File: rtl/counter_m_monitor.sv
// Checks an observed mod-M counter (sequence, range, carry) and keeps error/wrap tallies.
// Latency: verdicts are registered; err_pulse and the tallies update at the edge that samples the fault.
// No backpressure: the monitor samples every edge and never stalls the observed counter.
module counter_m_monitor #(
  parameter int M    = 10,
  parameter int ERRW = 8
) (
  input  logic                  clk,
  input  logic                  Reset,
  counter_m_monitor_if.slave    bus
);

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(M - 1);
  localparam logic [4:0] MOD_5   = 5'(M);

  state_t          state, state_nxt;
  logic [3:0]      prev_count;
  logic            prev_en;
  logic            locked_q;
  logic            err_pulse_q;
  logic            err_sticky_q;
  logic [ERRW-1:0] err_count_q;
  logic [ERRW-1:0] wrap_count_q;

  logic            range_err;
  logic            seq_err;
  logic            carry_err;
  logic            carry_exp;
  logic            fail;
  logic            wrap_hit;
  logic [3:0]      exp_count;

  // Evaluate all checks on the current sample and choose the next state.
  always_comb begin
    state_nxt = state;
    fail      = 1'b0;
    wrap_hit  = 1'b0;
    range_err = ({1'b0, bus.count_M} >= MOD_5);
    exp_count = prev_en ? ((prev_count == MAX_CNT) ? 4'd0 : prev_count + 4'd1) : prev_count;
    seq_err   = (bus.count_M != exp_count);
    carry_exp = (bus.count_M == MAX_CNT) && bus.enable;
    carry_err = (bus.carry_out_M != carry_exp);
    case (state)
      ACQUIRE: begin
        fail      = range_err;
        state_nxt = range_err ? ACQUIRE : LOCKED;
      end
      LOCKED: begin
        // Multiple simultaneous failures collapse into one fail.
        fail      = seq_err | range_err | carry_err;
        state_nxt = range_err ? ACQUIRE : LOCKED;
        wrap_hit  = prev_en && (prev_count == MAX_CNT) && (bus.count_M == 4'd0);
      end
      default: state_nxt = ACQUIRE;
    endcase
    if (bus.clear) begin
      state_nxt = ACQUIRE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= ACQUIRE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reference sample, status flags and tallies.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      prev_count   <= 4'd0;
      prev_en      <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else if (bus.clear) begin
      prev_count   <= 4'd0;
      prev_en      <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      // Every edge re-seeds from the current sample, which also covers the
      // re-seed after a sequence/range failure.
      prev_count  <= bus.count_M;
      prev_en     <= bus.enable;
      // locked mirrors the state register one edge later.
      locked_q    <= (state == LOCKED);
      err_pulse_q <= fail;
      if (fail) begin
        err_sticky_q <= 1'b1;
        if (err_count_q != {ERRW{1'b1}}) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
      if (wrap_hit) begin
        wrap_count_q <= wrap_count_q + 1'b1;
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_counter_m_monitor.sv
// Directed bench for counter_m_monitor with M=10, ERRW=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// A bench-side counter model supplies legal sequences; faults are injected explicitly.
module tb_counter_m_monitor;

  logic clk;
  logic Reset;
  int   checks;
  int   passed;
  int   cnt;
  int   exp_err;

  counter_m_monitor_if #(.ERRW(8)) bus ();

  counter_m_monitor #(.M(10), .ERRW(8)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one raw sample, let it be taken at the next edge, then settle.
  task automatic drive_raw(input int c, input logic en, input logic cy);
    bus.count_M     = 4'(c);
    bus.enable      = en;
    bus.carry_out_M = cy;
    @(posedge clk);
    #1;
  endtask

  // Drive the legal next value of the modelled counter.
  task automatic step_cnt(input logic en);
    drive_raw(cnt, en, (cnt == 9) && en);
    if (en) cnt = (cnt + 1) % 10;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    bus.clear = 1'b0;
    bus.enable = 1'b0;
    bus.count_M = 4'd0;
    bus.carry_out_M = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got %b want 0", bus.locked); else passed++;
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", bus.err_pulse); else passed++;
    checks++; if (bus.err_sticky !== 1'b0) $display("FAIL reset_sticky got %b want 0", bus.err_sticky); else passed++;
    checks++; if (bus.err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", bus.err_count); else passed++;
    checks++; if (bus.wrap_count !== 8'd0) $display("FAIL reset_wrap_count got %0d want 0", bus.wrap_count); else passed++;
    @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic test_basic;
    int pulses;
    pulses = 0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step_cnt(1'b1);
      if (bus.err_pulse) pulses++;
      if (i == 0) begin
        checks++; if (bus.locked !== 1'b0) $display("FAIL basic_locked_edge1 got %b want 0", bus.locked); else passed++;
      end
      if (i == 1) begin
        checks++; if (bus.locked !== 1'b1) $display("FAIL basic_locked_edge2 got %b want 1", bus.locked); else passed++;
      end
    end
    checks++; if (pulses != 0) $display("FAIL basic_pulses got %0d want 0", pulses); else passed++;
    checks++; if (bus.err_count !== 8'd0) $display("FAIL basic_err_count got %0d want 0", bus.err_count); else passed++;
    checks++; if (bus.wrap_count !== 8'd2) $display("FAIL basic_wrap_count got %0d want 2", bus.wrap_count); else passed++;
    checks++; if (bus.err_sticky !== 1'b0) $display("FAIL basic_sticky got %b want 0", bus.err_sticky); else passed++;
  endtask

  task automatic test_enable_toggle;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      step_cnt(((i / 3) % 2) == 0);
      if (bus.err_pulse) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL toggle_pulses got %0d want 0", pulses); else passed++;
    checks++; if (bus.err_count !== 8'd0) $display("FAIL toggle_err_count got %0d want 0", bus.err_count); else passed++;
  endtask

  task automatic test_hold_violation;
    step_cnt(1'b0);
    step_cnt(1'b0);
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL hold_ok_pulse got %b want 0", bus.err_pulse); else passed++;
    cnt = (cnt + 1) % 10;
    step_cnt(1'b0);
    exp_err++;
    checks++; if (bus.err_pulse !== 1'b1) $display("FAIL hold_change_pulse got %b want 1", bus.err_pulse); else passed++;
    step_cnt(1'b0);
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL hold_reseed_pulse got %b want 0", bus.err_pulse); else passed++;
  endtask

  task automatic test_jump;
    for (int i = 0; i < 12 && cnt != 3; i++) step_cnt(1'b1);
    step_cnt(1'b1);
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL jump_pre_pulse got %b want 0", bus.err_pulse); else passed++;
    cnt = 7;
    step_cnt(1'b1);
    exp_err++;
    checks++; if (bus.err_pulse !== 1'b1) $display("FAIL jump_pulse got %b want 1", bus.err_pulse); else passed++;
    checks++; if (bus.err_count !== 8'(exp_err)) $display("FAIL jump_err_count got %0d want %0d", bus.err_count, exp_err); else passed++;
    checks++; if (bus.err_sticky !== 1'b1) $display("FAIL jump_sticky got %b want 1", bus.err_sticky); else passed++;
    step_cnt(1'b1);
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL jump_track8_pulse got %b want 0", bus.err_pulse); else passed++;
    checks++; if (bus.locked !== 1'b1) $display("FAIL jump_track8_locked got %b want 1", bus.locked); else passed++;
  endtask

  task automatic test_carry;
    for (int i = 0; i < 12 && cnt != 4; i++) step_cnt(1'b1);
    drive_raw(4, 1'b1, 1'b1);
    cnt = 5;
    exp_err++;
    checks++; if (bus.err_pulse !== 1'b1) $display("FAIL carry_high_pulse got %b want 1", bus.err_pulse); else passed++;
    checks++; if (bus.err_count !== 8'(exp_err)) $display("FAIL carry_high_count got %0d want %0d", bus.err_count, exp_err); else passed++;
    for (int i = 0; i < 4; i++) step_cnt(1'b1);
    drive_raw(9, 1'b1, 1'b0);
    cnt = 0;
    exp_err++;
    checks++; if (bus.err_pulse !== 1'b1) $display("FAIL carry_low_pulse got %b want 1", bus.err_pulse); else passed++;
    checks++; if (bus.err_count !== 8'(exp_err)) $display("FAIL carry_low_count got %0d want %0d", bus.err_count, exp_err); else passed++;
    step_cnt(1'b1);
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL carry_after_pulse got %b want 0", bus.err_pulse); else passed++;
  endtask

  task automatic test_range;
    drive_raw(12, 1'b1, 1'b0);
    exp_err++;
    checks++; if (bus.err_pulse !== 1'b1) $display("FAIL range_pulse got %b want 1", bus.err_pulse); else passed++;
    cnt = 0;
    step_cnt(1'b1);
    checks++; if (bus.locked !== 1'b0) $display("FAIL range_unlocked got %b want 0", bus.locked); else passed++;
    step_cnt(1'b1);
    checks++; if (bus.locked !== 1'b1) $display("FAIL range_relock got %b want 1", bus.locked); else passed++;
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL range_relock_pulse got %b want 0", bus.err_pulse); else passed++;
    checks++; if (bus.err_count !== 8'(exp_err)) $display("FAIL range_count got %0d want %0d", bus.err_count, exp_err); else passed++;
    for (int i = 0; i < 300; i++) drive_raw(12, 1'b1, 1'b0);
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    checks++; if (bus.err_count !== 8'(exp_err)) $display("FAIL range_saturate got %0d want %0d", bus.err_count, exp_err); else passed++;
    checks++; if (bus.err_pulse !== 1'b1) $display("FAIL range_sat_pulse got %b want 1", bus.err_pulse); else passed++;
  endtask

  task automatic test_reset_mid_and_clear;
    cnt = 0;
    for (int i = 0; i < 4; i++) step_cnt(1'b1);
    #2;
    Reset = 1'b0;
    #1;
    checks++; if (bus.locked !== 1'b0) $display("FAIL midreset_locked got %b want 0", bus.locked); else passed++;
    checks++; if (bus.err_sticky !== 1'b0) $display("FAIL midreset_sticky got %b want 0", bus.err_sticky); else passed++;
    checks++; if (bus.err_count !== 8'd0) $display("FAIL midreset_err_count got %0d want 0", bus.err_count); else passed++;
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL midreset_pulse got %b want 0", bus.err_pulse); else passed++;
    @(negedge clk);
    Reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 11; i++) step_cnt(1'b1);
    cnt = 5;
    step_cnt(1'b1);
    checks++; if (bus.err_count !== 8'd1) $display("FAIL preclear_err_count got %0d want 1", bus.err_count); else passed++;
    checks++; if (bus.wrap_count !== 8'd1) $display("FAIL preclear_wrap_count got %0d want 1", bus.wrap_count); else passed++;
    bus.clear = 1'b1;
    step_cnt(1'b1);
    bus.clear = 1'b0;
    checks++; if (bus.err_count !== 8'd0) $display("FAIL clear_err_count got %0d want 0", bus.err_count); else passed++;
    checks++; if (bus.wrap_count !== 8'd0) $display("FAIL clear_wrap_count got %0d want 0", bus.wrap_count); else passed++;
    checks++; if (bus.err_sticky !== 1'b0) $display("FAIL clear_sticky got %b want 0", bus.err_sticky); else passed++;
    checks++; if (bus.locked !== 1'b0) $display("FAIL clear_locked got %b want 0", bus.locked); else passed++;
    step_cnt(1'b1);
    step_cnt(1'b1);
    checks++; if (bus.locked !== 1'b1) $display("FAIL clear_relock got %b want 1", bus.locked); else passed++;
    checks++; if (bus.err_pulse !== 1'b0) $display("FAIL clear_relock_pulse got %b want 0", bus.err_pulse); else passed++;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    cnt     = 0;
    exp_err = 0;
    test_reset();
    test_basic();
    test_enable_toggle();
    test_hold_violation();
    test_jump();
    test_carry();
    test_range();
    test_reset_mid_and_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
